// File: rtl/rr_stream_mux_pkg.sv
// Shared definitions for the round-robin stream multiplexer.
// MODE_SEL / MODE_RR encode the 'mode' input of rr_stream_mux.
package rr_stream_mux_pkg;
  localparam logic MODE_SEL = 1'b0;
  localparam logic MODE_RR  = 1'b1;
endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter.
// Ports:
//   req       - per-requester request vector
//   ptr       - index of the last granted requester (lowest priority now)
//   grant     - one-hot grant, all zero when nothing requests
//   grant_idx - encoded index of the granted requester (0 when no grant)
// The scan runs over {req, req & above_ptr}: the lower half holds only the
// requesters strictly above ptr, the upper half all requesters, so the first
// set bit found is the next requester after ptr with wrap at N-1 -> 0.
module rr_arbiter #(
  parameter  int N    = 4,
  localparam int SELW = $clog2(N)
) (
  input  logic [N-1:0]    req,
  input  logic [SELW-1:0] ptr,
  output logic [N-1:0]    grant,
  output logic [SELW-1:0] grant_idx
);

  logic [N-1:0]   above_ptr;
  logic [2*N-1:0] dbl_req;
  logic           found;

  always_comb begin
    above_ptr = '0;
    for (int i = 0; i < N; i++) begin
      above_ptr[i] = (SELW'(i) > ptr);
    end
    dbl_req = {req, req & above_ptr};
  end

  always_comb begin
    found     = 1'b0;
    grant_idx = '0;
    for (int j = 0; j < 2 * N; j++) begin
      if (!found && dbl_req[j]) begin
        found     = 1'b1;
        grant_idx = SELW'(j % N);
      end
    end
  end

  always_comb begin
    grant = '0;
    for (int i = 0; i < N; i++) begin
      grant[i] = found && (grant_idx == SELW'(i));
    end
  end

endmodule

// File: rtl/rr_stream_mux.sv
// N-channel stream multiplexer with a single registered output slot.
// Ports:
//   clk, rst_n           - clock (rising edge), async active-low reset
//   mode                 - MODE_SEL: take channel 'sel'; MODE_RR: round-robin
//   sel                  - channel index for MODE_SEL (>= N grants nothing)
//   in_data / in_valid   - N input channels, channel i at [i*WIDTH +: WIDTH]
//   in_ready             - per-channel ready, at most one bit set
//   out_data / out_ch    - registered word and its source channel
//   out_valid/out_ready  - output slot handshake
// Handshake: a word moves across any valid/ready pair at the rising edge
// where both are high. Producers hold valid and data until accepted and do
// not derive valid from ready; in_ready may depend combinationally on
// in_valid and out_ready. The slot reloads in the same cycle it drains, so
// full throughput is one word per cycle.
module rr_stream_mux
  import rr_stream_mux_pkg::*;
#(
  parameter  int WIDTH = 8,
  parameter  int N     = 4,
  localparam int SELW  = $clog2(N)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               mode,
  input  logic [SELW-1:0]    sel,
  input  logic [N*WIDTH-1:0] in_data,
  input  logic [N-1:0]       in_valid,
  output logic [N-1:0]       in_ready,
  output logic [WIDTH-1:0]   out_data,
  output logic [SELW-1:0]    out_ch,
  output logic               out_valid,
  input  logic               out_ready
);

  logic [SELW-1:0]  ptr;
  logic [N-1:0]     rr_grant;
  logic [SELW-1:0]  rr_idx;
  logic [N-1:0]     sel_grant;
  logic [N-1:0]     grant;
  logic [SELW-1:0]  grant_idx;
  logic             load;
  logic             xfer;
  logic [WIDTH-1:0] mux_data;

  rr_arbiter #(.N(N)) u_arb (
    .req       (in_valid),
    .ptr       (ptr),
    .grant     (rr_grant),
    .grant_idx (rr_idx)
  );

  // Comparing sel against each legal index means an out-of-range sel
  // (possible when N is not a power of two) simply matches nothing.
  always_comb begin
    sel_grant = '0;
    for (int i = 0; i < N; i++) begin
      sel_grant[i] = (sel == SELW'(i)) && in_valid[i];
    end
  end

  always_comb begin
    if (mode == MODE_RR) begin
      grant     = rr_grant;
      grant_idx = rr_idx;
    end else begin
      grant     = sel_grant;
      grant_idx = sel;
    end
  end

  assign load     = !out_valid || out_ready;
  assign in_ready = load ? grant : '0;
  assign xfer     = |in_ready;

  always_comb begin
    mux_data = '0;
    for (int i = 0; i < N; i++) begin
      if (grant[i]) mux_data = in_data[i*WIDTH +: WIDTH];
    end
  end

  // ptr resets to N-1 so channel 0 has first priority after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data  <= '0;
      out_ch    <= '0;
      out_valid <= 1'b0;
      ptr       <= SELW'(N - 1);
    end else if (xfer) begin
      out_data  <= mux_data;
      out_ch    <= grant_idx;
      out_valid <= 1'b1;
      ptr       <= grant_idx;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule
